// File: rtl/ram_boot_loader.sv
// Serial boot loader: assembles byte pairs into 16-bit words, writes them to RAM, then releases the CPU.
// Optional trailing checksum word is enabled by defining RAM_BOOT_LOADER_CHECKSUM_EN.
module ram_boot_loader #(
  parameter int LOAD_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic [11:0] cpu_address,
  input  logic        cpu_write,
  input  logic        cpu_read,
  input  logic [15:0] cpu_writedata,
  output logic [11:0] ram_address,
  output logic        ram_write,
  output logic        ram_read,
  output logic [15:0] ram_writedata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] RECV_HI  = 3'd0;
  localparam logic [2:0] RECV_LO  = 3'd1;
  localparam logic [2:0] WRITE    = 3'd2;
  localparam logic [2:0] DONE     = 3'd3;
`ifdef RAM_BOOT_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK_HI = 3'd4;
  localparam logic [2:0] CHECK_LO = 3'd5;
  localparam logic [2:0] ERROR    = 3'd6;
`endif

  // 13-bit counter so a full 4096-word load finishes without wrapping to 0
  localparam logic [12:0] LAST_WORD = 13'(LOAD_WORDS - 1);

  logic [2:0]  state;
  logic [12:0] word_count;
  logic [7:0]  hi, lo;
  logic        accept;
`ifdef RAM_BOOT_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  assign accept = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RECV_HI;
      word_count <= '0;
      hi         <= '0;
      lo         <= '0;
`ifdef RAM_BOOT_LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      case (state)
        RECV_HI: if (accept) begin
          hi    <= rx_data;
          state <= RECV_LO;
        end
        RECV_LO: if (accept) begin
          lo    <= rx_data;
          state <= WRITE;
        end
        WRITE: begin
          word_count <= word_count + 13'd1;
`ifdef RAM_BOOT_LOADER_CHECKSUM_EN
          checksum   <= checksum + {hi, lo};
          state      <= (word_count == LAST_WORD) ? CHECK_HI : RECV_HI;
`else
          state      <= (word_count == LAST_WORD) ? DONE : RECV_HI;
`endif
        end
`ifdef RAM_BOOT_LOADER_CHECKSUM_EN
        // checksum high byte reuses the hi register; the low byte is compared straight off the bus
        CHECK_HI: if (accept) begin
          hi    <= rx_data;
          state <= CHECK_LO;
        end
        CHECK_LO: if (accept) state <= ({hi, rx_data} == checksum) ? DONE : ERROR;
        ERROR:    state <= ERROR;
`endif
        DONE:    state <= DONE;
        default: state <= RECV_HI;
      endcase
    end
  end

  always_comb begin
    rx_ready      = 1'b0;
    ram_address   = word_count[11:0];
    ram_writedata = {hi, lo};
    ram_write     = 1'b0;
    ram_read      = 1'b0;
    cpu_reset     = 1'b1;
    done          = 1'b0;
    case (state)
      RECV_HI, RECV_LO: rx_ready = 1'b1;
`ifdef RAM_BOOT_LOADER_CHECKSUM_EN
      CHECK_HI, CHECK_LO: rx_ready = 1'b1;
`endif
      WRITE: ram_write = 1'b1;
      DONE: begin
        cpu_reset     = 1'b0;
        done          = 1'b1;
        ram_address   = cpu_address;
        ram_write     = cpu_write;
        ram_read      = cpu_read;
        ram_writedata = cpu_writedata;
      end
      default: ;
    endcase
  end

`ifdef RAM_BOOT_LOADER_CHECKSUM_EN
  assign error = (state == ERROR);
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_ram_boot_loader.sv
// Scoreboard bench for ram_boot_loader: three instances (4, 4096 and 2 words) share stimulus, each with its own reset.
module tb_ram_boot_loader;

`ifdef RAM_BOOT_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst [3];
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [11:0] cpu_address;
  logic        cpu_write, cpu_read;
  logic [15:0] cpu_writedata;
  logic        rx_ready [3];
  logic        ram_write [3];
  logic        ram_read [3];
  logic        cpu_reset [3];
  logic        done [3];
  logic        error [3];
  logic [11:0] ram_address [3];
  logic [15:0] ram_writedata [3];

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  byte_q [$];
  logic [15:0] words [$];
  logic [27:0] exp_q [$];
  int          wr_cyc [$];
  int          end_cyc;
  logic [11:0] last_addr;

  always #5 clk = ~clk;

  ram_boot_loader #(.LOAD_WORDS(4)) u0 (
    .clk(clk), .reset(rst[0]), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready[0]),
    .cpu_address(cpu_address), .cpu_write(cpu_write), .cpu_read(cpu_read), .cpu_writedata(cpu_writedata),
    .ram_address(ram_address[0]), .ram_write(ram_write[0]), .ram_read(ram_read[0]),
    .ram_writedata(ram_writedata[0]), .cpu_reset(cpu_reset[0]), .done(done[0]), .error(error[0]));

  ram_boot_loader #(.LOAD_WORDS(4096)) u1 (
    .clk(clk), .reset(rst[1]), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready[1]),
    .cpu_address(cpu_address), .cpu_write(cpu_write), .cpu_read(cpu_read), .cpu_writedata(cpu_writedata),
    .ram_address(ram_address[1]), .ram_write(ram_write[1]), .ram_read(ram_read[1]),
    .ram_writedata(ram_writedata[1]), .cpu_reset(cpu_reset[1]), .done(done[1]), .error(error[1]));

  ram_boot_loader #(.LOAD_WORDS(2)) u2 (
    .clk(clk), .reset(rst[2]), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready[2]),
    .cpu_address(cpu_address), .cpu_write(cpu_write), .cpu_read(cpu_read), .cpu_writedata(cpu_writedata),
    .ram_address(ram_address[2]), .ram_write(ram_write[2]), .ram_read(ram_read[2]),
    .ram_writedata(ram_writedata[2]), .cpu_reset(cpu_reset[2]), .done(done[2]), .error(error[2]));

  // Byte stream from the words queue, high byte first, optionally followed by sum+delta.
  function automatic void build(input bit add_chk, input logic [15:0] delta);
    logic [15:0] sum = '0;
    byte_q.delete();
    foreach (words[i]) begin
      byte_q.push_back(words[i][15:8]);
      byte_q.push_back(words[i][7:0]);
      sum = sum + words[i];
    end
    if (add_chk) begin
      sum = sum + delta;
      byte_q.push_back(sum[15:8]);
      byte_q.push_back(sum[7:0]);
    end
  endfunction

  // Holds every instance in reset for two edges with a byte on offer, then releases instance s.
  task automatic do_reset(input int s);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    rx_valid = 1'b1; rx_data = 8'hEE;
    cpu_write = 1'b0; cpu_read = 1'b0; cpu_address = '0; cpu_writedata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst[s] = 1'b0;
    rx_valid = 1'b0;
    exp_q.delete();
  endtask

  // Drives byte_q into instance s; expected writes are queued as bytes are accepted and popped on ram_write.
  task automatic run_stream(input int s, input int nload, input bit rnd, input int budget);
    int bi = 0, cyc = 0, idle = 0;
    logic [7:0]  hib = '0;
    logic [27:0] e;
    wr_cyc.delete();
    end_cyc = 0;
    while (1) begin
      if (bi < byte_q.size() && (!rnd || $urandom_range(0, 1) == 1)) begin
        rx_valid = 1'b1; rx_data = byte_q[bi];
      end else begin
        rx_valid = 1'b0; rx_data = 8'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (ram_write[s]) begin
        wr_cyc.push_back(cyc);
        last_addr = ram_address[s];
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected: got addr %h data %h, required no write", ram_address[s], ram_writedata[s]);
        end else begin
          e = exp_q.pop_front();
          if ({ram_address[s], ram_writedata[s]} !== e) begin
            n_fail++;
            $display("FAIL write_data: got addr %h data %h, required addr %h data %h",
                     ram_address[s], ram_writedata[s], e[27:16], e[15:0]);
          end
        end
        n_chk++;
        if (cpu_reset[s] !== 1'b1 || ram_read[s] !== 1'b0) begin
          n_fail++;
          $display("FAIL load_ctrl: got cpu_reset %b ram_read %b, required 1 0", cpu_reset[s], ram_read[s]);
        end
      end
      if (done[s] === 1'b1 || error[s] === 1'b1) begin
        end_cyc = cyc;
        break;
      end
      if (rx_valid && rx_ready[s]) begin
        if (bi < 2 * nload) begin
          if (bi % 2 == 0) hib = rx_data;
          else exp_q.push_back({12'(bi / 2), hib, rx_data});
        end
        bi++;
      end
      if (bi >= byte_q.size()) idle++;
      if (cyc >= budget || idle > 4) break;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL writes_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset;
    do_reset(0);
    cpu_write = 1'b1; cpu_read = 1'b1;
    #1;
    n_chk++;
    if ({rx_ready[0], ram_write[0], ram_read[0], cpu_reset[0], done[0], error[0]} !== 6'b100100) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 100100",
               {rx_ready[0], ram_write[0], ram_read[0], cpu_reset[0], done[0], error[0]});
    end
    n_chk++;
    if (ram_address[0] !== 12'h000 || ram_writedata[0] !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_regs: got addr %h data %h, required 000 0000", ram_address[0], ram_writedata[0]);
    end
    cpu_write = 1'b0; cpu_read = 1'b0;
  endtask

  task automatic test_back_to_back;
    words = {16'h1234, 16'hABCD, 16'h0001, 16'hFFFF};
    build(CHK_EN, 16'h0000);
    do_reset(0);
    run_stream(0, 4, 1'b0, 100);
    n_chk++;
    if (wr_cyc.size() != 4) begin
      n_fail++;
      $display("FAIL b2b_write_count: got %0d, required 4", wr_cyc.size());
    end else begin
      foreach (wr_cyc[i]) begin
        n_chk++;
        if (wr_cyc[i] != 3 * (i + 1)) begin
          n_fail++;
          $display("FAIL b2b_write_cycle: got %0d, required %0d", wr_cyc[i], 3 * (i + 1));
        end
      end
    end
    n_chk++;
    if (end_cyc != (CHK_EN ? 15 : 13) || done[0] !== 1'b1 || cpu_reset[0] !== 1'b0 || error[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: got cycle %0d done %b cpu_reset %b error %b, required cycle %0d 1 0 0",
               end_cyc, done[0], cpu_reset[0], error[0], CHK_EN ? 15 : 13);
    end
  endtask

  task automatic test_random_valid;
    words = {16'h1234, 16'hABCD, 16'h0001, 16'hFFFF};
    build(CHK_EN, 16'h0000);
    do_reset(0);
    run_stream(0, 4, 1'b1, 400);
    n_chk++;
    if (wr_cyc.size() != 4 || done[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rand_valid: got %0d writes done %b, required 4 writes done 1", wr_cyc.size(), done[0]);
    end
  endtask

  // Runs with instance 0 in DONE from the previous load.
  task automatic test_cpu_passthrough;
    cpu_address = 12'h005; cpu_write = 1'b1; cpu_writedata = 16'hBEEF;
    rx_valid = 1'b1; rx_data = 8'h55;
    #1;
    n_chk++;
    if (ram_address[0] !== 12'h005 || ram_write[0] !== 1'b1 || ram_writedata[0] !== 16'hBEEF || rx_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_write_pass: got addr %h we %b data %h rdy %b, required 005 1 beef 0",
               ram_address[0], ram_write[0], ram_writedata[0], rx_ready[0]);
    end
    cpu_address = 12'hABC; cpu_write = 1'b0; cpu_read = 1'b1;
    #1;
    n_chk++;
    if (ram_address[0] !== 12'hABC || ram_read[0] !== 1'b1 || ram_write[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_read_pass: got addr %h rd %b we %b, required abc 1 0", ram_address[0], ram_read[0], ram_write[0]);
    end
    cpu_read = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (done[0] !== 1'b1 || rx_ready[0] !== 1'b0 || ram_write[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL done_hold: got done %b rdy %b we %b, required 1 0 0", done[0], rx_ready[0], ram_write[0]);
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load;
    words = {16'h1111, 16'h2222, 16'h3333};
    build(1'b0, 16'h0000);
    do_reset(0);
    run_stream(0, 4, 1'b0, 40);
    n_chk++;
    if (wr_cyc.size() != 3 || done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_load: got %0d writes done %b, required 3 writes done 0", wr_cyc.size(), done[0]);
    end
    words = {16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4};
    build(CHK_EN, 16'h0000);
    do_reset(0);
    run_stream(0, 4, 1'b0, 100);
    n_chk++;
    if (wr_cyc.size() != 4 || done[0] !== 1'b1 || end_cyc <= wr_cyc[wr_cyc.size() - 1]) begin
      n_fail++;
      $display("FAIL restart_load: got %0d writes done %b at cycle %0d, required 4 writes then done", wr_cyc.size(), done[0], end_cyc);
    end
  endtask

  task automatic test_checksum;
    words = {16'h0001, 16'h0002};
    build(1'b1, 16'h0000);
    do_reset(2);
    run_stream(2, 2, 1'b0, 50);
    n_chk++;
    if (done[2] !== 1'b1 || error[2] !== 1'b0 || cpu_reset[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL checksum_good: got done %b error %b cpu_reset %b, required 1 0 0", done[2], error[2], cpu_reset[2]);
    end
    build(1'b1, 16'h0001);
    do_reset(2);
    run_stream(2, 2, 1'b0, 50);
    n_chk++;
    if (error[2] !== 1'b1 || cpu_reset[2] !== 1'b1 || done[2] !== 1'b0 || rx_ready[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL checksum_bad: got error %b cpu_reset %b done %b rdy %b, required 1 1 0 0",
               error[2], cpu_reset[2], done[2], rx_ready[2]);
    end
    rx_valid = 1'b1; rx_data = 8'h77;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (error[2] !== 1'b1 || ram_write[2] !== 1'b0 || done[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL error_hold: got error %b we %b done %b, required 1 0 0", error[2], ram_write[2], done[2]);
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_full_load;
    words.delete();
    for (int i = 0; i < 4096; i++) words.push_back(16'($urandom));
    build(CHK_EN, 16'h0000);
    do_reset(1);
    run_stream(1, 4096, 1'b0, 13000);
    n_chk++;
    if (wr_cyc.size() != 4096 || last_addr !== 12'hFFF || done[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL full_load: got %0d writes last %h done %b, required 4096 fff 1", wr_cyc.size(), last_addr, done[1]);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    rx_valid = 1'b0; rx_data = '0;
    cpu_address = '0; cpu_write = 1'b0; cpu_read = 1'b0; cpu_writedata = '0;
    test_reset();
    test_back_to_back();
    test_cpu_passthrough();
    test_random_valid();
    test_reset_mid_load();
    if (CHK_EN) test_checksum();
    test_full_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
